// File: rtl/cdb_scheduler.sv
// Common data bus slot scheduler: grants issue to int/ls/mult/div only when the
// unit's result slot on the CDB is free, then drives the CDB mux select/valid.
module cdb_scheduler #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issueint_req,
    input  logic        issuels_req,
    input  logic        issuemult_req,
    input  logic        issuediv_req,
    input  logic        issuediv_busy,
    output logic        issueint_grant,
    output logic        issuels_grant,
    output logic        issuemult_grant,
    output logic        issuediv_grant,
    output logic [1:0]  cdb_src,
    output logic        cdb_valid,
    output logic [15:0] cdb_conflicts
);

    localparam logic [1:0] SRC_INT  = 2'd0;
    localparam logic [1:0] SRC_LS   = 2'd1;
    localparam logic [1:0] SRC_MULT = 2'd2;
    localparam logic [1:0] SRC_DIV  = 2'd3;

    // Slot i is the CDB cycle i cycles from now; slot 0 is on the bus now.
    logic [DIV_LAT:0]       v_q;
    logic [DIV_LAT:0]       v_d;
    logic [DIV_LAT:0][1:0]  own_q;
    logic [DIV_LAT:0][1:0]  own_d;
    logic                   rr_q;
    logic                   rr_d;
    logic [15:0]            conf_q;
    logic [15:0]            conf_d;

    logic int_g;
    logic ls_g;
    logic mult_g;
    logic div_g;
    logic refused;

    always_comb begin
        int_g  = 1'b0;
        ls_g   = 1'b0;
        mult_g = 1'b0;
        div_g  = 1'b0;
        rr_d   = rr_q;
        if (reset) begin
            div_g  = issuediv_req & ~issuediv_busy & ~v_q[DIV_LAT];
            mult_g = issuemult_req & ~v_q[MULT_LAT];
            if (!v_q[1]) begin
                if (issueint_req && issuels_req) begin
                    int_g = ~rr_q;
                    ls_g  = rr_q;
                    rr_d  = ~rr_q;
                end else begin
                    int_g = issueint_req;
                    ls_g  = issuels_req;
                end
            end
        end
    end

    // A grant of latency L books slot L-1 of the next cycle, which is slot L now.
    for (genvar gi = 0; gi < DIV_LAT; gi++) begin : g_slot
        logic       slot_grant;
        logic [1:0] slot_code;

        always_comb begin
            slot_grant = 1'b0;
            slot_code  = SRC_INT;
            if (gi == 0) begin
                if (int_g) begin
                    slot_grant = 1'b1;
                    slot_code  = SRC_INT;
                end else if (ls_g) begin
                    slot_grant = 1'b1;
                    slot_code  = SRC_LS;
                end
            end
            if (gi == MULT_LAT - 1 && mult_g) begin
                slot_grant = 1'b1;
                slot_code  = SRC_MULT;
            end
            if (gi == DIV_LAT - 1 && div_g) begin
                slot_grant = 1'b1;
                slot_code  = SRC_DIV;
            end
        end

        assign v_d[gi]   = v_q[gi+1] | slot_grant;
        assign own_d[gi] = slot_grant ? slot_code : own_q[gi+1];
    end

    assign v_d[DIV_LAT]   = 1'b0;
    assign own_d[DIV_LAT] = SRC_INT;

    assign refused = (issueint_req  & ~int_g)  |
                     (issuels_req   & ~ls_g)   |
                     (issuemult_req & ~mult_g) |
                     (issuediv_req  & ~div_g);

    always_comb begin
        conf_d = conf_q;
        if (refused && conf_q != 16'hFFFF) begin
            conf_d = conf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= '0;
            own_q  <= '0;
            rr_q   <= 1'b0;
            conf_q <= 16'd0;
        end else begin
            v_q    <= v_d;
            own_q  <= own_d;
            rr_q   <= rr_d;
            conf_q <= conf_d;
        end
    end

    assign issueint_grant  = int_g;
    assign issuels_grant   = ls_g;
    assign issuemult_grant = mult_g;
    assign issuediv_grant  = div_g;
    assign cdb_valid       = v_q[0];
    assign cdb_src         = own_q[0];
    assign cdb_conflicts   = conf_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Self-checking bench for cdb_scheduler: directed scenarios plus random traffic
// compared against a calendar model of booked CDB cycles.
module tb_cdb_scheduler;

    localparam int ML   = 4;
    localparam int DL   = 7;
    localparam int RING = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issueint_req = 1'b0;
    logic        issuels_req = 1'b0;
    logic        issuemult_req = 1'b0;
    logic        issuediv_req = 1'b0;
    logic        issuediv_busy = 1'b0;
    logic        issueint_grant;
    logic        issuels_grant;
    logic        issuemult_grant;
    logic        issuediv_grant;
    logic [1:0]  cdb_src;
    logic        cdb_valid;
    logic [15:0] cdb_conflicts;

    int checks = 0;
    int failures = 0;

    // Calendar model: which absolute cycle carries which unit's result.
    bit         cal_v [RING];
    logic [1:0] cal_s [RING];
    int         cyc;
    bit         m_rr;
    int         m_conf;
    logic       g_int, g_ls, g_mult, g_div;

    cdb_scheduler #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset),
        .issueint_req(issueint_req), .issuels_req(issuels_req),
        .issuemult_req(issuemult_req), .issuediv_req(issuediv_req),
        .issuediv_busy(issuediv_busy),
        .issueint_grant(issueint_grant), .issuels_grant(issuels_grant),
        .issuemult_grant(issuemult_grant), .issuediv_grant(issuediv_grant),
        .cdb_src(cdb_src), .cdb_valid(cdb_valid), .cdb_conflicts(cdb_conflicts)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < RING; i++) begin
            cal_v[i] = 1'b0;
            cal_s[i] = 2'd0;
        end
        m_rr = 1'b0;
        m_conf = 0;
        cyc = 0;
    endtask

    // One bus cycle; called just after a rising edge.
    task automatic step(input logic ir, input logic lr, input logic mr,
                        input logic dr, input logic db);
        bit e_int, e_ls, e_mult, e_div, free1, refused;
        issueint_req = ir;
        issuels_req = lr;
        issuemult_req = mr;
        issuediv_req = dr;
        issuediv_busy = db;
        #3;
        free1 = !cal_v[(cyc + 1) % RING];
        e_int = 1'b0;
        e_ls = 1'b0;
        if (free1) begin
            if (ir && lr) begin
                e_int = !m_rr;
                e_ls = m_rr;
            end else begin
                e_int = ir;
                e_ls = lr;
            end
        end
        e_mult = mr && !cal_v[(cyc + ML) % RING];
        e_div = dr && !db && !cal_v[(cyc + DL) % RING];

        checks++;
        if (issueint_grant !== e_int) begin
            failures++;
            $display("FAIL int_grant cyc=%0d got=%b exp=%b", cyc, issueint_grant, e_int);
        end
        checks++;
        if (issuels_grant !== e_ls) begin
            failures++;
            $display("FAIL ls_grant cyc=%0d got=%b exp=%b", cyc, issuels_grant, e_ls);
        end
        checks++;
        if (issuemult_grant !== e_mult) begin
            failures++;
            $display("FAIL mult_grant cyc=%0d got=%b exp=%b", cyc, issuemult_grant, e_mult);
        end
        checks++;
        if (issuediv_grant !== e_div) begin
            failures++;
            $display("FAIL div_grant cyc=%0d got=%b exp=%b", cyc, issuediv_grant, e_div);
        end
        checks++;
        if (cdb_valid !== cal_v[cyc % RING]) begin
            failures++;
            $display("FAIL cdb_valid cyc=%0d got=%b exp=%b", cyc, cdb_valid, cal_v[cyc % RING]);
        end
        if (cal_v[cyc % RING]) begin
            checks++;
            if (cdb_src !== cal_s[cyc % RING]) begin
                failures++;
                $display("FAIL cdb_src cyc=%0d got=%0d exp=%0d", cyc, cdb_src, cal_s[cyc % RING]);
            end
        end
        checks++;
        if (cdb_conflicts !== 16'(m_conf)) begin
            failures++;
            $display("FAIL conflicts cyc=%0d got=%0d exp=%0d", cyc, cdb_conflicts, m_conf);
        end

        refused = (ir && !e_int) || (lr && !e_ls) || (mr && !e_mult) || (dr && !e_div);
        if (refused && m_conf < 65535) m_conf++;
        if (ir && lr && free1) m_rr = !m_rr;
        cal_v[cyc % RING] = 1'b0;
        if (e_int) begin cal_v[(cyc + 1) % RING] = 1'b1; cal_s[(cyc + 1) % RING] = 2'd0; end
        if (e_ls) begin cal_v[(cyc + 1) % RING] = 1'b1; cal_s[(cyc + 1) % RING] = 2'd1; end
        if (e_mult) begin cal_v[(cyc + ML) % RING] = 1'b1; cal_s[(cyc + ML) % RING] = 2'd2; end
        if (e_div) begin cal_v[(cyc + DL) % RING] = 1'b1; cal_s[(cyc + DL) % RING] = 2'd3; end

        g_int = issueint_grant;
        g_ls = issuels_grant;
        g_mult = issuemult_grant;
        g_div = issuediv_grant;
        $display("cyc=%0d req=%b%b%b%b busy=%b grant=%b%b%b%b cdb_v=%b src=%0d conf=%0d",
                 cyc, ir, lr, mr, dr, db, g_int, g_ls, g_mult, g_div,
                 cdb_valid, cdb_src, cdb_conflicts);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Hold reset low for two cycles with all requests high, then release.
    task automatic do_reset();
        reset = 1'b0;
        issueint_req = 1'b1;
        issuels_req = 1'b1;
        issuemult_req = 1'b1;
        issuediv_req = 1'b1;
        issuediv_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if ({issueint_grant, issuels_grant, issuemult_grant, issuediv_grant} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_grants got=%b exp=0000",
                         {issueint_grant, issuels_grant, issuemult_grant, issuediv_grant});
            end
            checks++;
            if (cdb_valid !== 1'b0 || cdb_src !== 2'd0 || cdb_conflicts !== 16'd0) begin
                failures++;
                $display("FAIL reset_state got=v%b s%0d c%0d exp=v0 s0 c0",
                         cdb_valid, cdb_src, cdb_conflicts);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        idle(2);
    endtask

    task automatic test_int_alone();
        do_reset();
        idle(5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (g_int !== 1'b1) begin
            failures++;
            $display("FAIL int_alone_grant got=%b exp=1", g_int);
        end
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) begin
            failures++;
            $display("FAIL int_alone_cdb got=v%b s%0d exp=v1 s0", cdb_valid, cdb_src);
        end
        idle(1);
        checks++;
        if (cdb_valid !== 1'b0 || cdb_conflicts !== 16'd0) begin
            failures++;
            $display("FAIL int_alone_after got=v%b c%0d exp=v0 c0", cdb_valid, cdb_conflicts);
        end
    endtask

    task automatic test_int_ls_rr();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (g_int !== 1'((k + 1) % 2) || g_ls !== 1'(k % 2)) begin
                failures++;
                $display("FAIL rr_alternate k=%0d got=%b%b exp=%b%b", k, g_int, g_ls,
                         1'((k + 1) % 2), 1'(k % 2));
            end
        end
        checks++;
        if (cdb_conflicts !== 16'd4) begin
            failures++;
            $display("FAIL rr_conflicts got=%0d exp=4", cdb_conflicts);
        end
        idle(2);
    endtask

    task automatic test_div_mult();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (g_div !== 1'b1) begin
            failures++;
            $display("FAIL div_grant_first got=%b exp=1", g_div);
        end
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (g_mult !== 1'b0) begin
            failures++;
            $display("FAIL mult_blocked_by_div got=%b exp=0", g_mult);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (g_mult !== 1'b1) begin
            failures++;
            $display("FAIL mult_after_div got=%b exp=1", g_mult);
        end
        idle(6);
    endtask

    task automatic test_mult_int();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (g_int !== 1'b0) begin
            failures++;
            $display("FAIL int_blocked_by_mult got=%b exp=0", g_int);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (g_int !== 1'b1) begin
            failures++;
            $display("FAIL int_after_mult got=%b exp=1", g_int);
        end
        idle(3);
    endtask

    task automatic test_div_busy();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (g_div !== 1'b0) begin
                failures++;
                $display("FAIL div_busy k=%0d got=%b exp=0", k, g_div);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (g_div !== 1'b1 || cdb_conflicts !== 16'd3) begin
            failures++;
            $display("FAIL div_unbusy got=g%b c%0d exp=g1 c3", g_div, cdb_conflicts);
        end
        idle(8);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cdb_valid !== 1'b1) begin
            failures++;
            $display("FAIL midflight_pre got=%b exp=1", cdb_valid);
        end
        issueint_req = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_src !== 2'd0 || issueint_grant !== 1'b0) begin
            failures++;
            $display("FAIL midflight_async got=v%b s%0d g%b exp=v0 s0 g0",
                     cdb_valid, cdb_src, issueint_grant);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        idle(10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (g_int !== 1'b1 || g_ls !== 1'b0) begin
            failures++;
            $display("FAIL midflight_rr got=%b%b exp=10", g_int, g_ls);
        end
        idle(2);
    endtask

    // Random traffic obeying the hold-until-granted handshake.
    task automatic test_random();
        bit p_int, p_ls, p_mult, p_div, busy;
        do_reset();
        p_int = 0; p_ls = 0; p_mult = 0; p_div = 0;
        for (int k = 0; k < 400; k++) begin
            if (!p_int) p_int = ($urandom_range(0, 99) < 45);
            if (!p_ls) p_ls = ($urandom_range(0, 99) < 45);
            if (!p_mult) p_mult = ($urandom_range(0, 99) < 30);
            if (!p_div) p_div = ($urandom_range(0, 99) < 20);
            busy = ($urandom_range(0, 3) == 0);
            step(p_int, p_ls, p_mult, p_div, busy);
            if (g_int) p_int = 0;
            if (g_ls) p_ls = 0;
            if (g_mult) p_mult = 0;
            if (g_div) p_div = 0;
        end
        idle(DL + 1);
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_int_alone();
        test_int_ls_rr();
        test_div_mult();
        test_mult_int();
        test_div_busy();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
